// File: rtl/arb_req_agent.sv
// arb_req_agent
//   Requester-side agent between one command source and one round-robin
//   arbiter port. Commands are buffered in a small FIFO. While work is
//   pending the agent raises req. Each gnt pulse issues exactly one command
//   onto the shared bus. After each issue, req drops for one cycle so the
//   arbiter can rotate. The agent also tracks worst-case grant latency and
//   flags grants that arrive outside WAIT.
//
// Ports
//   clk, rst      clock (rising edge); synchronous active-high reset
//   in_valid/in_ready/in_data   command push side (push = valid & ready)
//   req           request to arbiter port (state == WAIT)
//   gnt           single-cycle grant pulse from arbiter port
//   out_valid/out_data          one-cycle issue strobe and payload
//   max_wait      sticky largest grant latency (WAIT cycles before grant)
//   spurious_gnt  sticky: gnt seen while not in WAIT
//   clr_stats     clears max_wait and spurious_gnt (wins over updates)
module arb_req_agent #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req,
    input  logic          gnt,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [CW-1:0] max_wait,
    output logic          spurious_gnt,
    input  logic          clr_stats
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   wait_cnt;
    logic            push, pop;

    // No full bypass: a pop does not free a slot for the same edge.
    assign in_ready = ~rst & (count != FULL_CNT);
    assign push     = in_valid & in_ready;
    assign pop      = (state == WAIT) & gnt;
    assign req      = (state == WAIT);

    // Storage needs no reset; push is held off while rst is high.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // HOLD looks at the post-pop count, so req returns only if work remains.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = WAIT;
            WAIT:    if (gnt) state_nxt = HOLD;
            HOLD:    state_nxt = (count != '0) ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue register: strobe only in the cycle after a WAIT grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= pop;
            if (pop) out_data <= mem[rd_ptr];
        end
    end

    // Latency counter restarts on every entry into WAIT and saturates.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state != WAIT && state_nxt == WAIT)
            wait_cnt <= '0;
        else if (state == WAIT && !gnt && wait_cnt != '1)
            wait_cnt <= wait_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_wait     <= '0;
            spurious_gnt <= 1'b0;
        end else if (clr_stats) begin
            max_wait     <= '0;
            spurious_gnt <= 1'b0;
        end else begin
            if (pop && wait_cnt > max_wait) max_wait <= wait_cnt;
            if (gnt && state != WAIT)       spurious_gnt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent. The stimulus process queues each
// expected issue payload when it drives a grant. A separate monitor pops
// and compares on every out_valid strobe.
module tb_arb_req_agent;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       req;
    logic       gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic [3:0] max_wait;
    logic       spurious_gnt;
    logic       clr_stats;

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q [$];
    logic       prev_ov = 1'b0;

    always #5 clk = ~clk;

    arb_req_agent #(.DW(8), .DEPTH(4), .CW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .req          (req),
        .gnt          (gnt),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .max_wait     (max_wait),
        .spurious_gnt (spurious_gnt),
        .clr_stats    (clr_stats)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: every strobe must match the next queued payload.
    always @(negedge clk) begin
        if (out_valid) begin
            chk("issue_not_back_to_back", 32'(prev_ov), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("issue_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
        prev_ov = out_valid;
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Drive a grant pulse for one cycle; the issue must follow next cycle.
    task automatic do_grant(input logic [7:0] exp);
        gnt = 1'b1;
        exp_q.push_back(exp);
        step();
        gnt = 1'b0;
        chk("req_drop_after_grant", 32'(req), 0);
    endtask

    task automatic push1(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!req && n < 20) begin
            step();
            n++;
        end
        chk(name, 32'(req), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; gnt = 1'b0; clr_stats = 1'b0;
        repeat (2) step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_req", 32'(req), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_max_wait", 32'(max_wait), 0);
        chk("rst_spurious", 32'(spurious_gnt), 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 1);

        // Single command, grant in third req cycle
        push1(8'hA5);
        chk("t1_req_same_edge", 32'(req), 0);
        step();
        chk("t1_req_next_edge", 32'(req), 1);
        step();
        step();
        chk("t1_req_third", 32'(req), 1);
        do_grant(8'hA5);
        chk("t1_max_wait", 32'(max_wait), 2);
        step();
        chk("t1_idle_req", 32'(req), 0);
        step();
        chk("t1_idle_req2", 32'(req), 0);

        // Fill FIFO, refuse a fifth offer while full
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            step();
        end
        chk("t2_full_in_ready", 32'(in_ready), 0);
        in_data = 8'h05;
        step();
        chk("t2_full_hold", 32'(in_ready), 0);
        chk("t2_req_up", 32'(req), 1);
        do_grant(8'h01);
        chk("t2_ready_returns", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("t2_refull", 32'(in_ready), 0);
        for (int i = 2; i <= 5; i++) begin
            chk("t2_req_back", 32'(req), 1);
            step();
            do_grant(8'(i));
            step();
        end
        chk("t2_drained_req", 32'(req), 0);

        // Grant outside WAIT: IDLE, then HOLD
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("t3_spur_idle", 32'(spurious_gnt), 1);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("t3_clr_spur", 32'(spurious_gnt), 0);
        chk("t3_clr_max", 32'(max_wait), 0);
        push1(8'h33);
        wait_req("t3_wait_req");
        do_grant(8'h33);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("t3_spur_hold", 32'(spurious_gnt), 1);
        chk("t3_max_first_cycle", 32'(max_wait), 0);
        repeat (3) step();
        chk("t3_spur_sticky", 32'(spurious_gnt), 1);
        chk("t3_no_req", 32'(req), 0);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk("t3_clr_again", 32'(spurious_gnt), 0);

        // Saturation at CW=4
        push1(8'h44);
        wait_req("t4_wait_req");
        repeat (20) step();
        chk("t4_req_held", 32'(req), 1);
        do_grant(8'h44);
        chk("t4_max_sat", 32'(max_wait), 15);
        step();

        // Clear collides with a grant at wait_cnt = 3
        push1(8'h55);
        wait_req("t5_wait_req");
        repeat (3) step();
        clr_stats = 1'b1;
        do_grant(8'h55);
        clr_stats = 1'b0;
        chk("t5_clear_wins", 32'(max_wait), 0);
        step();

        // Reset with three entries queued
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h61 + 8'(i);
            step();
        end
        in_valid = 1'b0;
        chk("t6_req_before_rst", 32'(req), 1);
        rst = 1'b1;
        step();
        chk("t6_rst_req", 32'(req), 0);
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        step();
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_spur_cleared", 32'(spurious_gnt), 0);
        step();
        chk("t6_empty_no_req", 32'(req), 0);
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        chk("t6_spur_set", 32'(spurious_gnt), 1);
        repeat (2) step();
        chk("t6_still_idle", 32'(req), 0);

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
